rvmyth_out_uart_tx: RTL and testbench
=====================================

# rvmyth_out_uart_tx

Observation transmitter for the RVMyth core's 10-bit `out` bus. It sits in the core's PLL-generated clock domain. Each cycle it samples the core output and detects value changes. Changed samples go into a small FIFO, and each one is shipped off-chip as a two-byte 8N1 UART frame on a single pad. Off-chip logic can then follow program results without 10 output pads.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per UART bit; legal range 2..1023.
- `FIFO_DEPTH`, default 8: sample FIFO entries; power of two, 2..64.
- `clk` input 1: PLL output clock, the same net that drives the core; all logic on the rising edge.
- `reset` input 1: synchronous, active-high; the same reset that drives the core.
- `core_out` input 10: the core's `out` bus, sampled every rising edge.
- `tx` output 1: UART serial line, idle high.
- `busy` output 1: high while a frame is being serialized or the FIFO is non-empty.
- `overflow` output 1: sticky; set when a sample is dropped because the FIFO is full.
- `fifo_level` output clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Capture.** Register `prev` holds the last sampled `core_out`. Flag `first` is set by reset.
  - A push request occurs on an edge where `first` is 1 or `core_out != prev`.
  - `prev <= core_out` on every non-reset edge, whether or not the push is accepted.
  - `first` clears on the first non-reset edge.
- **FIFO.** Circular buffer of FIFO_DEPTH x 10 bits with wrapping read/write pointers.
  - A push is accepted if `fifo_level < FIFO_DEPTH`, or if a pop occurs on the same edge.
  - Otherwise the sample is dropped and `overflow <= 1`.
  - A simultaneous push and pop leaves `fifo_level` unchanged.
- **Framing.** Each sample S becomes two bytes, sent back-to-back with no idle gap:
  - B0 = {1'b1, 2'b00, S[9:5]}: bit 7 = 1 marks the high byte, for receiver resync.
  - B1 = {1'b0, 2'b00, S[4:0]}.
  - Each byte is 8N1: start bit 0, data bits LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
- **TX state machine.** States IDLE, START, DATA, STOP. Supporting registers:
  - bit counter, 0..7;
  - baud counter, 0..CLKS_PER_BIT-1;
  - `byte_sel`, 0 = B0, 1 = B1;
  - 10-bit `hold` register.
- **Transitions.**
  - IDLE -> START: when the FIFO is non-empty. Pop into `hold`, set `byte_sel=0`, `tx` driven 0.
  - START -> DATA: after CLKS_PER_BIT cycles.
  - DATA -> STOP: after 8 bit periods.
  - STOP, end of stop bit, `byte_sel=0`: go to START, `byte_sel <= 1`.
  - STOP, end of stop bit, `byte_sel=1`: go to IDLE. If the FIFO is non-empty, the IDLE->START pop happens on the very next edge.
- **Output register.** `tx` is a registered output; it has no combinational path from the FIFO or `core_out`.

## Timing
- **Reset values.** `tx=1`, `busy=0`, `overflow=0`, `fifo_level=0`. Also: pointers 0, `prev=0`, `first=1`, state IDLE.
- **Reset mid-frame.** The frame is abandoned. `tx` is 1 after the reset edge, and FIFO contents are discarded. The first sample after reset deassert is always pushed.
- **Latency.** Let edge N be the edge at which a change is sampled with the FIFO empty and TX IDLE.
  - The sample is written at edge N, and `fifo_level=1` after N.
  - The pop occurs at edge N+1, and `tx` falls after edge N+1.
  - `fifo_level` returns to 0 after N+1.
- **Frame length.** Exactly 20*CLKS_PER_BIT cycles per sample, from the start of B0's start bit to the end of B1's stop bit.
- **Sustained throughput.** One sample per 20*CLKS_PER_BIT+1 cycles, which includes the one IDLE cycle.
- **`busy`.** Asserted from the cycle after the push edge until the end of the last stop bit with the FIFO empty.
- **Wrap-around.** Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by `fifo_level`, not by pointer equality alone.
- **`overflow`.** Cleared only by reset.

## Test plan
Unless noted, all scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- **Post-reset report.** Release reset with `core_out=10'h000` held.
  - Exactly one sample is sent: B0=8'h80, B1=8'h00.
  - Then `tx` stays high, `busy=0`, and no further frames follow.
- **Single change.** Change `core_out` to 10'h2A5 at edge N.
  - `tx` low after N+1.
  - Bytes decoded: B0=8'h95, B1=8'h05.
  - Frame spans 80 cycles; `busy` falls after the last stop bit.
- **Overflow and drop.** Change `core_out` on 6 consecutive edges: 001, 002, ..., 006.
  - Transmitted: 001, 002, 003, 004, 005; 006 is dropped.
  - `overflow=1` from the edge after 006 is sampled; `fifo_level` peaks at 4.
  - Sample 005 is accepted because the edge on which it is sampled coincides with the pop of 001.
- **Back-to-back and wrap.** Push 10 distinct values, spaced so the FIFO never fills.
  - All 10 are received in order, with pointers wrapping twice.
  - Consecutive frames are separated by exactly one idle cycle.
- **Reset mid-frame.** Assert reset during bit 3 of B1.
  - `tx=1` on the next cycle, `fifo_level=0`, `overflow=0`.
  - After release, the current `core_out` is retransmitted in full.
- **Baud scaling.** CLKS_PER_BIT=16, value 10'h3FF.
  - B0=8'h9F, B1=8'h1F.
  - Each bit is measured at exactly 16 cycles.

Source files
------------

// File: rtl/rvmyth_out_uart_tx.sv
// RVMyth output observer: captures changes on the core's 10-bit out bus,
// queues them in a small FIFO and serializes each one as two 8N1 UART bytes
// (high byte tagged with bit 7 = 1 so a receiver can resynchronize).
module rvmyth_out_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [9:0]                    core_out,
   output logic                          tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [PTR_W:0]    LEVEL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   // capture / FIFO bookkeeping
   logic [9:0]       prev_reg;
   logic             first_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   level_reg;
   logic             overflow_reg;
   logic [9:0]       mem [FIFO_DEPTH];

   // serializer
   logic [1:0]        state_reg;
   logic [BAUD_W-1:0] baud_reg;
   logic [2:0]        bit_reg;
   logic              byte_sel_reg;
   logic [9:0]        hold_reg;
   logic              tx_reg;

   logic       push_req;
   logic       push_ok;
   logic       pop;
   logic [7:0] cur_byte;
   logic [2:0] bit_next;

   // A change (or the very first sample after reset) requests a push; a pop
   // frees a slot on the same edge, so a full FIFO still accepts in that case.
   assign push_req = first_reg || (core_out != prev_reg);
   assign pop      = (state_reg == S_IDLE) && (level_reg != '0);
   assign push_ok  = push_req && ((level_reg < LEVEL_FULL) || pop);
   assign bit_next = bit_reg + 3'd1;
   assign cur_byte = byte_sel_reg ? {3'b000, hold_reg[4:0]}
                                  : {3'b100, hold_reg[9:5]};

   assign tx         = tx_reg;
   assign busy       = (state_reg != S_IDLE) || (level_reg != '0);
   assign overflow   = overflow_reg;
   assign fifo_level = level_reg;

   // Change detection, FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_reg     <= '0;
         first_reg    <= 1'b1;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         prev_reg  <= core_out;
         first_reg <= 1'b0;
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         if (push_req && !push_ok)
            overflow_reg <= 1'b1;
         case ({push_ok, pop})
            2'b10:   level_reg <= level_reg + (PTR_W + 1)'(1);
            2'b01:   level_reg <= level_reg - (PTR_W + 1)'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

   // Sample storage with registered read into the hold register on pop.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_reg] <= core_out;
      if (pop)
         hold_reg <= mem[rd_ptr_reg];
   end

   // Two-byte 8N1 serializer; tx is driven only from this register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         baud_reg     <= '0;
         bit_reg      <= '0;
         byte_sel_reg <= 1'b0;
         tx_reg       <= 1'b1;
      end else begin
         case (state_reg)
            S_IDLE: begin
               tx_reg <= 1'b1;
               if (pop) begin
                  state_reg    <= S_START;
                  baud_reg     <= '0;
                  byte_sel_reg <= 1'b0;
                  tx_reg       <= 1'b0;
               end
            end
            S_START: begin
               if (baud_reg == BAUD_LAST) begin
                  baud_reg  <= '0;
                  bit_reg   <= '0;
                  state_reg <= S_DATA;
                  tx_reg    <= cur_byte[0];
               end else begin
                  baud_reg <= baud_reg + BAUD_W'(1);
               end
            end
            S_DATA: begin
               if (baud_reg == BAUD_LAST) begin
                  baud_reg <= '0;
                  if (bit_reg == 3'd7) begin
                     state_reg <= S_STOP;
                     tx_reg    <= 1'b1;
                  end else begin
                     bit_reg <= bit_next;
                     tx_reg  <= cur_byte[bit_next];
                  end
               end else begin
                  baud_reg <= baud_reg + BAUD_W'(1);
               end
            end
            S_STOP: begin
               if (baud_reg == BAUD_LAST) begin
                  baud_reg <= '0;
                  if (!byte_sel_reg) begin
                     state_reg    <= S_START;
                     byte_sel_reg <= 1'b1;
                     tx_reg       <= 1'b0;
                  end else begin
                     state_reg <= S_IDLE;
                  end
               end else begin
                  baud_reg <= baud_reg + BAUD_W'(1);
               end
            end
            default: begin
               state_reg <= S_IDLE;
               tx_reg    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rvmyth_out_uart_tx.sv
// Self-checking bench for rvmyth_out_uart_tx: a queue/arithmetic reference
// model predicts tx, busy, fifo_level and overflow every cycle, a UART
// receiver decodes the line, and directed sequences cover the corner cases.
module tb_rvmyth_out_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 20 * CPB;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, reset16;
   logic [9:0] core_out, core16;
   logic       tx, busy, overflow;
   logic [2:0] fifo_level;
   logic       tx16, busy16, ovf16;
   logic [3:0] level16;

   rvmyth_out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .core_out(core_out), .tx(tx), .busy(busy),
      .overflow(overflow), .fifo_level(fifo_level));

   rvmyth_out_uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(8)) dut16 (
      .clk(clk), .reset(reset16), .core_out(core16), .tx(tx16), .busy(busy16),
      .overflow(ovf16), .fifo_level(level16));

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // reference model state
   logic [9:0] mq[$];
   logic [9:0] m_sent[$];
   logic       m_first = 1'b1;
   logic [9:0] m_prev  = '0;
   logic       m_ovf   = 1'b0;
   int         m_pop   = -1;
   int         m_ready = 0;
   logic [9:0] m_cur   = '0;
   logic       last_rst = 1'b1;

   // receiver state
   bit         rx_active = 0;
   int         rx_i, rx_start, hi_start;
   logic [7:0] rx_byte;
   bit         hi_valid = 0;
   logic [4:0] hi;
   logic [7:0] rx_bytes[$];
   logic [9:0] rx_samples[$];
   int         rx_fstart[$];

   logic t16q[$];
   bit   cap16 = 0;

   typedef struct {
      logic       rst;
      logic [9:0] core;
      int         level;
      logic       busy;
      logic       ovf;
      logic       tx;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Line level implied by the frame in flight: bit k of the 20-bit frame.
   function automatic logic model_tx();
      int t, k, pos;
      logic [7:0] byt;
      if (m_pop < 0) return 1'b1;
      t = cyc - m_pop;
      if (t >= FRAME) return 1'b1;
      k   = t / CPB;
      pos = k % 10;
      byt = (k < 10) ? {3'b100, m_cur[9:5]} : {3'b000, m_cur[4:0]};
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return byt[pos-1];
   endfunction

   function automatic logic model_busy();
      return (mq.size() > 0) || (m_pop >= 0 && (cyc - m_pop) < FRAME);
   endfunction

   // Advance the model across the coming edge using the inputs now applied.
   task automatic model_step();
      cyc++;
      if (reset) begin
         mq.delete();
         m_first = 1'b1;
         m_prev  = '0;
         m_ovf   = 1'b0;
         m_pop   = -1;
         m_ready = 0;
      end else begin
         if (cyc >= m_ready && mq.size() > 0) begin
            m_cur = mq.pop_front();
            m_sent.push_back(m_cur);
            m_pop   = cyc;
            m_ready = cyc + FRAME + 1;
         end
         if (m_first || core_out != m_prev) begin
            if (mq.size() < DEPTH) mq.push_back(core_out);
            else m_ovf = 1'b1;
         end
         m_prev  = core_out;
         m_first = 1'b0;
      end
      last_rst = reset;
   endtask

   // Mid-bit sampling UART receiver on the line value of the current cycle.
   task automatic rx_step();
      int k;
      if (last_rst) begin
         rx_active = 0;
         hi_valid  = 0;
      end else begin
         if (!rx_active) begin
            if (tx == 1'b0) begin
               rx_active = 1;
               rx_i      = 0;
               rx_start  = cyc;
               rx_byte   = '0;
            end
         end else begin
            rx_i++;
         end
         if (rx_active && (rx_i % CPB) == CPB / 2) begin
            k = rx_i / CPB;
            if (k >= 1 && k <= 8) begin
               rx_byte[k-1] = tx;
            end else if (k == 9) begin
               check("stop_bit", tx, 1);
               rx_active = 0;
               rx_bytes.push_back(rx_byte);
               if (rx_byte[7]) begin
                  hi       = rx_byte[4:0];
                  hi_valid = 1;
                  hi_start = rx_start;
               end else if (hi_valid) begin
                  rx_samples.push_back({hi, rx_byte[4:0]});
                  rx_fstart.push_back(hi_start);
                  hi_valid = 0;
               end
            end
         end
      end
   endtask

   task automatic cycle();
      rx_step();
      model_step();
      if (cap16) t16q.push_back(tx16);
      @(posedge clk);
      @(negedge clk);
      check("tx", tx, model_tx());
      check("busy", busy, model_busy());
      check("fifo_level", fifo_level, mq.size());
      check("overflow", overflow, m_ovf);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      cycle();
      cycle();
      while (busy !== 1'b0 && n < budget) begin
         cycle();
         n++;
      end
      check(name, busy, 0);
   endtask

   task automatic clear_logs();
      rx_bytes.delete();
      rx_samples.delete();
      rx_fstart.delete();
      m_sent.delete();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t       vecs[8];
      int         cnt, g, peak, f, idx, len, seed, nrem, nb;
      logic       lvl;
      logic [9:0] vals[10];
      logic [9:0] xval;
      logic [7:0] b0, b1;
      int         exp_runs[7];
      logic [9:0] exp_ovf_seq[6];

      reset = 1'b1; core_out = '0; reset16 = 1'b1; core16 = 10'h3FF;
      exp_runs    = '{16, 80, 32, 32, 16, 80, 48};
      exp_ovf_seq = '{10'h100, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005};
      @(negedge clk);

      // ---- reset state and post-reset report, first cycles tabulated ----
      vecs[0] = '{1'b1, 10'h000, 0, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{1'b1, 10'h000, 0, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 10'h000, 1, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 10'h000, 0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 10'h000, 0, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 10'h000, 0, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 10'h000, 0, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 10'h000, 0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         reset    = vecs[i].rst;
         core_out = vecs[i].core;
         cycle();
         check($sformatf("vec%0d_level", i), fifo_level, vecs[i].level);
         check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
         check($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
         check($sformatf("vec%0d_tx", i), tx, vecs[i].tx);
      end
      wait_idle("post_reset_idle", 500);
      check("post_reset_nbytes", rx_bytes.size(), 2);
      if (rx_bytes.size() == 2) begin
         check("post_reset_b0", rx_bytes[0], 8'h80);
         check("post_reset_b1", rx_bytes[1], 8'h00);
      end
      repeat (40) cycle();
      check("post_reset_quiet", rx_bytes.size(), 2);
      check("post_reset_tx_high", tx, 1);

      // ---- single change ----
      clear_logs();
      core_out = 10'h2A5;
      cycle();
      check("single_level_N", fifo_level, 1);
      check("single_tx_N", tx, 1);
      cycle();
      check("single_tx_N1", tx, 0);
      check("single_level_N1", fifo_level, 0);
      cnt = 1;
      g   = 0;
      while (busy === 1'b1 && g < 200) begin
         cycle();
         if (busy === 1'b1) cnt++;
         g++;
      end
      check("single_busy_cycles", cnt, FRAME);
      check("single_nbytes", rx_bytes.size(), 2);
      if (rx_bytes.size() == 2) begin
         check("single_b0", rx_bytes[0], 8'h95);
         check("single_b1", rx_bytes[1], 8'h05);
      end

      // ---- overflow: sample 005 lands on the pop edge of 001 ----
      clear_logs();
      core_out = 10'h100;
      cycle();
      g = 0;
      while (cyc + 1 != m_ready - 4 && g < 300) begin
         cycle();
         g++;
      end
      check("ovf_align", g < 300, 1);
      peak = 0;
      for (int v = 1; v <= 6; v++) begin
         core_out = 10'(v);
         cycle();
         if (int'(fifo_level) > peak) peak = int'(fifo_level);
         if (v == 4) check("ovf_level_after_004", fifo_level, 4);
         if (v == 5) begin
            check("ovf_clear_after_005", overflow, 0);
            check("ovf_level_after_005", fifo_level, 4);
         end
      end
      check("ovf_set_after_006", overflow, 1);
      check("ovf_level_after_006", fifo_level, 4);
      wait_idle("ovf_idle", 1000);
      check("ovf_peak", peak, 4);
      check("ovf_nsamples", rx_samples.size(), 6);
      if (rx_samples.size() == 6)
         for (int i = 0; i < 6; i++)
            check($sformatf("ovf_sample%0d", i), rx_samples[i], exp_ovf_seq[i]);

      // ---- back-to-back frames with pointer wrap ----
      clear_logs();
      seed = $urandom_range(0, 1023);
      while (seed == 6) seed = $urandom_range(0, 1023);
      for (int i = 0; i < 10; i++) vals[i] = 10'((seed + i * 101) % 1024);
      for (int i = 0; i < 10; i++) begin
         core_out = vals[i];
         cycle();
         repeat (59) cycle();
      end
      wait_idle("wrap_idle", 1000);
      check("wrap_ovf_sticky", overflow, 1);
      check("wrap_nsamples", rx_samples.size(), 10);
      if (rx_samples.size() == 10) begin
         for (int i = 0; i < 10; i++)
            check($sformatf("wrap_sample%0d", i), rx_samples[i], vals[i]);
         for (int i = 1; i < 10; i++)
            check($sformatf("wrap_gap%0d", i), rx_fstart[i] - rx_fstart[i-1], FRAME + 1);
      end

      // ---- reset during bit 3 of B1 ----
      clear_logs();
      xval = 10'h1C3;
      core_out = xval;
      cycle();
      g = 0;
      while (!(m_pop >= 0 && cyc - m_pop == 57) && g < 300) begin
         cycle();
         g++;
      end
      check("rst_align", g < 300, 1);
      reset = 1'b1;
      cycle();
      check("rst_tx", tx, 1);
      check("rst_level", fifo_level, 0);
      check("rst_ovf", overflow, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      clear_logs();
      wait_idle("rst_idle", 500);
      check("rst_nsamples", rx_samples.size(), 1);
      if (rx_samples.size() == 1) check("rst_resend", rx_samples[0], xval);

      // ---- baud scaling: CLKS_PER_BIT=16, value 3FF ----
      reset16 = 1'b0;
      cap16   = 1;
      repeat (400) cycle();
      cap16 = 0;
      f = -1;
      for (int i = 0; i < t16q.size(); i++)
         if (f < 0 && t16q[i] == 1'b0) f = i;
      check("baud_frame_seen", f >= 0, 1);
      if (f >= 0) begin
         idx = f;
         for (int r = 0; r < 7; r++) begin
            lvl = t16q[idx];
            len = 0;
            while (idx < t16q.size() && t16q[idx] == lvl) begin
               len++;
               idx++;
            end
            check($sformatf("baud_run%0d", r), len, exp_runs[r]);
         end
         len = 0;
         while (idx < t16q.size() && t16q[idx] == 1'b1) begin
            len++;
            idx++;
         end
         check("baud_idle_after", len >= 40 && idx == t16q.size(), 1);
         if (f + 320 <= t16q.size()) begin
            for (int k = 0; k < 8; k++) begin
               b0[k] = t16q[f + 16 * (k + 1) + 8];
               b1[k] = t16q[f + 160 + 16 * (k + 1) + 8];
            end
            check("baud_b0", b0, 8'h9F);
            check("baud_b1", b1, 8'h1F);
         end
      end
      check("baud_busy", busy16, 0);
      check("baud_level", level16, 0);
      check("baud_ovf", ovf16, 0);

      // ---- randomized traffic against the reference model ----
      clear_logs();
      nrem = 3000;
      while (nrem > 0) begin
         if ($urandom_range(0, 9) < 2) begin
            nb = $urandom_range(2, 8);
            for (int j = 0; j < nb; j++) begin
               core_out = 10'($urandom);
               cycle();
            end
            nrem -= nb;
         end else begin
            core_out = 10'($urandom);
            nb = $urandom_range(1, 150);
            repeat (nb) cycle();
            nrem -= nb;
         end
      end
      wait_idle("rand_idle", 2000);
      check("rand_nsamples", rx_samples.size(), m_sent.size());
      for (int i = 0; i < rx_samples.size() && i < m_sent.size(); i++)
         check($sformatf("rand_sample%0d", i), rx_samples[i], m_sent[i]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
